// File: rtl/sass_seq_pkg.sv
// sass_seq_pkg
// Shared note-code definitions for the sequencer and piano paths.
// Provides the note_t type, the chromatic note constants (OFF, LOW_C .. HIGH_C)
// and the next_note helper that advances a note code with wrap-around.
// No ports: package only.
package sass_seq_pkg;

    localparam int NOTE_W   = 4;
    localparam int NOTE_MAX = 13;

    typedef logic [NOTE_W-1:0] note_t;

    // Chromatic scale, low C to high C. Codes 14 and 15 are never stored.
    localparam note_t OFF    = 4'd0;
    localparam note_t LOW_C  = 4'd1;
    localparam note_t C_S    = 4'd2;
    localparam note_t D_N    = 4'd3;
    localparam note_t D_S    = 4'd4;
    localparam note_t E_N    = 4'd5;
    localparam note_t F_N    = 4'd6;
    localparam note_t F_S    = 4'd7;
    localparam note_t G_N    = 4'd8;
    localparam note_t G_S    = 4'd9;
    localparam note_t A_N    = 4'd10;
    localparam note_t A_S    = 4'd11;
    localparam note_t B_N    = 4'd12;
    localparam note_t HIGH_C = 4'd13;

    // Advance a note by one semitone; high C wraps back to OFF so a player can
    // cycle through every value including silence with a single button.
    function automatic note_t next_note(input note_t n);
        return (n >= note_t'(NOTE_MAX)) ? OFF : note_t'(n + 1'b1);
    endfunction

endpackage

// File: rtl/seq_gate_timer.sv
// seq_gate_timer
// Loadable down-counter that times how long a triggered note keeps sounding.
//   clk    in  system clock
//   rst    in  synchronous active-high reset, clears the counter
//   load   in  start a new gate: counter <= GATE_LEN-1
//   kill   in  abort the gate: counter <= 0
//   active out counter is nonzero, i.e. the current note must be held
module seq_gate_timer #(
    parameter int GATE_LEN = 2500
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic kill,
    output logic active
);

    localparam int CNT_W = $clog2(GATE_LEN + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(GATE_LEN - 1);

    logic [CNT_W-1:0] count;

    // The note is already visible on the load edge, so loading GATE_LEN-1 and
    // holding while the count is nonzero yields exactly GATE_LEN sounding cycles.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign active = (count != '0);

endmodule

// File: rtl/sequencer_track.sv
// sequencer_track
// Multi-step note sequencer track: one stored note per step, editable by the
// player, replayed with a fixed gate length on every beat change.
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   sequencer_on in  1 = sequencer mode, 0 = piano mode
//   beat         in  current beat from the measure counter
//   edit_step    in  step selected for editing / display
//   toggle       in  single-cycle pulse, advances the note at edit_step
//   clear_step   in  pulse, sets the note at edit_step to OFF
//   clear_all    in  pulse, sets every step to OFF
//   note_out     out note being played (0 = OFF)
//   gate         out high while note_out is sounding
//   edit_note    out registered note stored at edit_step (display)
module sequencer_track
    import sass_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int BEAT_W    = 4,
    parameter int GATE_LEN  = 2500
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sequencer_on,
    input  logic [BEAT_W-1:0]            beat,
    input  logic [$clog2(NUM_STEPS)-1:0] edit_step,
    input  logic                         toggle,
    input  logic                         clear_step,
    input  logic                         clear_all,
    output logic [NOTE_W-1:0]            note_out,
    output logic                         gate,
    output logic [NOTE_W-1:0]            edit_note
);

    note_t             mem      [NUM_STEPS];
    note_t             mem_next [NUM_STEPS];
    note_t             beat_note;
    note_t             edit_sel;
    note_t             note_q;
    logic [BEAT_W-1:0] beat_q;
    logic              on_q;
    logic              trig;
    logic              timer_load;
    logic              timer_kill;
    logic              timer_active;

    // Note stored at the current beat, or OFF when the beat lies beyond the
    // last step. Reads the pre-edit memory so a same-cycle edit of the playing
    // step only affects the next trigger.
    always_comb begin
        beat_note = OFF;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (int'(beat) == i) begin
                beat_note = mem[i];
            end
        end
    end

    // Edit logic: clear_all beats clear_step beats toggle. Out-of-range steps
    // and piano mode leave the memory untouched.
    always_comb begin
        mem_next = mem;
        if (sequencer_on) begin
            if (clear_all) begin
                for (int i = 0; i < NUM_STEPS; i++) begin
                    mem_next[i] = OFF;
                end
            end else begin
                for (int i = 0; i < NUM_STEPS; i++) begin
                    if (int'(edit_step) == i) begin
                        if (clear_step) begin
                            mem_next[i] = OFF;
                        end else if (toggle) begin
                            mem_next[i] = next_note(mem[i]);
                        end
                    end
                end
            end
        end
    end

    // Display value is taken from the post-edit memory so an edit shows up on
    // the same edge it is written.
    always_comb begin
        edit_sel = OFF;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (int'(edit_step) == i) begin
                edit_sel = mem_next[i];
            end
        end
    end

    // A trigger fires on every beat change and also when the sequencer is
    // switched on, so the current beat plays immediately.
    assign trig       = sequencer_on && ((beat != beat_q) || !on_q);
    assign timer_load = trig && (beat_note != OFF);
    assign timer_kill = !sequencer_on || (trig && (beat_note == OFF));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                mem[i] <= OFF;
            end
            edit_note <= OFF;
            beat_q    <= '0;
            on_q      <= 1'b0;
        end else begin
            mem       <= mem_next;
            edit_note <= edit_sel;
            beat_q    <= beat;
            on_q      <= sequencer_on;
        end
    end

    // Output note: a trigger always replaces the previous note (silence for an
    // OFF step), otherwise the note holds until the gate timer runs out.
    always_ff @(posedge clk) begin
        if (rst || !sequencer_on) begin
            note_q <= OFF;
        end else if (trig) begin
            note_q <= beat_note;
        end else if (!timer_active) begin
            note_q <= OFF;
        end
    end

    seq_gate_timer #(
        .GATE_LEN (GATE_LEN)
    ) u_gate_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .kill   (timer_kill),
        .active (timer_active)
    );

    assign note_out = note_q;
    assign gate     = (note_q != OFF);

endmodule

// File: tb/tb_sequencer_track.sv
// tb_sequencer_track
// Drives two sequencer_track instances (8 steps / gate 5 and 6 steps / gate 3)
// from the same inputs and compares them every cycle against a behavioural
// model, plus directed sequences with hand-computed expectations.
module tb_sequencer_track;

    logic       clk = 1'b0;
    logic       rst;
    logic       sequencer_on;
    logic [3:0] beat;
    logic [2:0] edit_step;
    logic       toggle;
    logic       clear_step;
    logic       clear_all;

    logic [3:0] note_out_a;
    logic [3:0] edit_note_a;
    logic       gate_a;
    logic [3:0] note_out_b;
    logic [3:0] edit_note_b;
    logic       gate_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sequencer_track #(
        .NUM_STEPS (8),
        .BEAT_W    (4),
        .GATE_LEN  (5)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .sequencer_on (sequencer_on),
        .beat         (beat),
        .edit_step    (edit_step),
        .toggle       (toggle),
        .clear_step   (clear_step),
        .clear_all    (clear_all),
        .note_out     (note_out_a),
        .gate         (gate_a),
        .edit_note    (edit_note_a)
    );

    sequencer_track #(
        .NUM_STEPS (6),
        .BEAT_W    (4),
        .GATE_LEN  (3)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .sequencer_on (sequencer_on),
        .beat         (beat),
        .edit_step    (edit_step),
        .toggle       (toggle),
        .clear_step   (clear_step),
        .clear_all    (clear_all),
        .note_out     (note_out_b),
        .gate         (gate_b),
        .edit_note    (edit_note_b)
    );

    // Behavioural model: step memory as plain integers, and the sounding note
    // as "how many more cycles it stays visible".
    int steps_of [2] = '{8, 6};
    int glen_of  [2] = '{5, 3};
    int m_mem    [2][16];
    int m_note   [2];
    int m_rem    [2];
    int m_edit   [2];
    int m_prev_beat [2];
    bit m_prev_on   [2];
    bit m_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        n_checks++;
        if (actual !== 32'(expected)) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic on, input logic [3:0] b,
                                 input logic [2:0] es, input logic tg, input logic cs,
                                 input logic ca);
        rst          = r;
        sequencer_on = on;
        beat         = b;
        edit_step    = es;
        toggle       = tg;
        clear_step   = cs;
        clear_all    = ca;
        @(posedge clk);
        #2;
    endtask

    // Model update on every active edge from the inputs presented that cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int j = 0; j < 16; j++) m_mem[k][j] = 0;
                m_note[k] = 0;
                m_rem[k]  = 0;
                m_edit[k] = 0;
                m_prev_beat[k] = 0;
                m_prev_on[k]   = 1'b0;
            end else begin
                int  b;
                int  es;
                bit  trg;
                int  n;
                b  = int'(beat);
                es = int'(edit_step);
                trg = sequencer_on && ((b != m_prev_beat[k]) || !m_prev_on[k]);
                if (!sequencer_on) begin
                    m_note[k] = 0;
                    m_rem[k]  = 0;
                end else if (trg) begin
                    n = (b < steps_of[k]) ? m_mem[k][b] : 0;
                    m_note[k] = n;
                    m_rem[k]  = (n != 0) ? glen_of[k] : 0;
                end else if (m_rem[k] > 1) begin
                    m_rem[k]--;
                end else begin
                    m_note[k] = 0;
                    m_rem[k]  = 0;
                end
                if (sequencer_on) begin
                    if (clear_all) begin
                        for (int j = 0; j < 16; j++) m_mem[k][j] = 0;
                    end else if (es < steps_of[k]) begin
                        if (clear_step) m_mem[k][es] = 0;
                        else if (toggle) m_mem[k][es] = (m_mem[k][es] + 1) % 14;
                    end
                end
                m_edit[k] = (es < steps_of[k]) ? m_mem[k][es] : 0;
                m_prev_beat[k] = b;
                m_prev_on[k]   = sequencer_on;
            end
        end
        m_valid = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("a.note_out",  note_out_a,  m_note[0]);
            checkOutput("a.gate",      gate_a,      (m_note[0] != 0) ? 1 : 0);
            checkOutput("a.edit_note", edit_note_a, m_edit[0]);
            checkOutput("b.note_out",  note_out_b,  m_note[1]);
            checkOutput("b.gate",      gate_b,      (m_note[1] != 0) ? 1 : 0);
            checkOutput("b.edit_note", edit_note_b, m_edit[1]);
        end
    end

    initial begin
        logic [3:0] rb   [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        int         rexp [7] = '{1, 1, 1, 5, 5, 5, 0};
        logic       r_r, r_on, r_tg, r_cs, r_ca;
        logic [3:0] r_b;
        logic [2:0] r_es;

        // Reset state
        applyStimulus(1, 0, 4'd0, 3'd0, 0, 0, 0);
        checkOutput("reset note_out", note_out_a, 0);
        checkOutput("reset gate", gate_a, 0);
        checkOutput("reset edit_note", edit_note_a, 0);

        // Program step 2 to D and play it for the full gate
        repeat (3) applyStimulus(0, 1, 4'd0, 3'd2, 1, 0, 0);
        checkOutput("edit_note three toggles", edit_note_a, 3);
        checkOutput("beat0 silent", note_out_a, 0);
        applyStimulus(0, 1, 4'd1, 3'd2, 0, 0, 0);
        checkOutput("beat1 silent", note_out_a, 0);
        applyStimulus(0, 1, 4'd2, 3'd2, 0, 0, 0);
        checkOutput("beat2 note", note_out_a, 3);
        checkOutput("beat2 gate", gate_a, 1);
        repeat (4) applyStimulus(0, 1, 4'd2, 3'd2, 0, 0, 0);
        checkOutput("gate last cycle", note_out_a, 3);
        applyStimulus(0, 1, 4'd2, 3'd2, 0, 0, 0);
        checkOutput("gate expired note", note_out_a, 0);
        checkOutput("gate expired gate", gate_a, 0);

        // Toggle wrap on step 0
        for (int i = 1; i <= 14; i++) begin
            applyStimulus(0, 1, 4'd2, 3'd0, 1, 0, 0);
            if (i == 13) checkOutput("toggle reaches 13", edit_note_a, 13);
        end
        checkOutput("toggle wraps to 0", edit_note_a, 0);
        applyStimulus(0, 1, 4'd2, 3'd0, 1, 0, 0);
        checkOutput("toggle after wrap", edit_note_a, 1);
        applyStimulus(0, 1, 4'd2, 3'd0, 1, 1, 0);
        checkOutput("clear_step beats toggle", edit_note_a, 0);

        // Steps 0/1 = 1/5, step 2 OFF, beats every 3 cycles
        applyStimulus(0, 1, 4'd2, 3'd0, 1, 0, 0);
        repeat (5) applyStimulus(0, 1, 4'd2, 3'd1, 1, 0, 0);
        checkOutput("step1 programmed", edit_note_a, 5);
        applyStimulus(0, 1, 4'd2, 3'd2, 0, 1, 0);
        checkOutput("step2 cleared", edit_note_a, 0);
        applyStimulus(0, 1, 4'd7, 3'd0, 0, 0, 0);
        checkOutput("beat7 silent", note_out_a, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1, rb[i], 3'd0, 0, 0, 0);
            checkOutput($sformatf("retrigger cycle %0d", i), note_out_a, rexp[i]);
        end

        // Sequencer off cuts the note and ignores edits; re-enable retriggers
        applyStimulus(0, 1, 4'd0, 3'd0, 0, 0, 0);
        checkOutput("beat0 replay", note_out_a, 1);
        applyStimulus(0, 0, 4'd0, 3'd0, 1, 0, 0);
        checkOutput("off cuts note", note_out_a, 0);
        checkOutput("off cuts gate", gate_a, 0);
        checkOutput("off ignores toggle", edit_note_a, 1);
        applyStimulus(0, 0, 4'd1, 3'd0, 1, 0, 0);
        checkOutput("off stays silent", note_out_a, 0);
        applyStimulus(0, 1, 4'd1, 3'd0, 0, 0, 0);
        checkOutput("re-enable triggers", note_out_a, 5);
        checkOutput("off toggles lost", edit_note_a, 1);

        // clear_all with every step programmed
        for (int es = 2; es < 8; es++) applyStimulus(0, 1, 4'd1, 3'(es), 1, 0, 0);
        checkOutput("step7 programmed", edit_note_a, 1);
        applyStimulus(0, 1, 4'd1, 3'd0, 0, 0, 1);
        for (int es = 0; es < 8; es++) begin
            applyStimulus(0, 1, 4'd1, 3'(es), 0, 0, 0);
            checkOutput($sformatf("clear_all step %0d", es), edit_note_a, 0);
        end
        applyStimulus(0, 1, 4'd3, 3'd0, 0, 0, 0);
        checkOutput("after clear_all beat", note_out_a, 0);

        // Same-cycle edit and trigger uses the pre-edit value
        applyStimulus(0, 1, 4'd4, 3'd3, 0, 0, 0);
        applyStimulus(0, 1, 4'd3, 3'd3, 1, 0, 0);
        checkOutput("pre-edit playback", note_out_a, 0);
        checkOutput("same-cycle edit stored", edit_note_a, 1);
        applyStimulus(0, 1, 4'd4, 3'd3, 0, 0, 0);
        applyStimulus(0, 1, 4'd3, 3'd3, 0, 0, 0);
        checkOutput("post-edit playback", note_out_a, 1);

        // Reset mid-gate with a toggle in the same cycle
        applyStimulus(1, 1, 4'd3, 3'd3, 1, 0, 0);
        checkOutput("mid-gate reset note", note_out_a, 0);
        checkOutput("mid-gate reset gate", gate_a, 0);
        checkOutput("mid-gate reset edit_note", edit_note_a, 0);
        applyStimulus(0, 1, 4'd3, 3'd3, 0, 0, 0);
        checkOutput("toggle lost in reset", edit_note_a, 0);
        checkOutput("memory cleared by reset", note_out_a, 0);

        // Out-of-range beat
        applyStimulus(0, 1, 4'd12, 3'd3, 0, 0, 0);
        checkOutput("out-of-range beat", note_out_a, 0);

        // Randomised phase, checked every cycle by the compare process
        r_b = 4'd0;
        for (int i = 0; i < 2500; i++) begin
            r_r  = ($urandom_range(63) == 0);
            r_on = ($urandom_range(9) != 0);
            if ($urandom_range(3) == 0) r_b = 4'($urandom_range(15));
            r_es = 3'($urandom_range(7));
            r_tg = ($urandom_range(2) == 0);
            r_cs = ($urandom_range(15) == 0);
            r_ca = ($urandom_range(63) == 0);
            applyStimulus(r_r, r_on, r_b, r_es, r_tg, r_cs, r_ca);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
